// File: rtl/bram_arbiter_if.sv
// Requester and BRAM-side signal bundle for the three-port BRAM arbiter.
// The slave modport is the arbiter's view; master is the requester/BRAM-side view.
interface bram_arbiter_if #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_BITS = 8
);
  logic                 p0_req, p1_req, p2_req;
  logic                 p0_wen, p1_wen, p2_wen;
  logic [ADDR_BITS-1:0] p0_addr, p1_addr, p2_addr;
  logic [DATA_BITS-1:0] p0_wdata, p1_wdata, p2_wdata;
  logic                 p0_gnt, p1_gnt, p2_gnt;
  logic                 p0_rvalid, p1_rvalid, p2_rvalid;
  logic [DATA_BITS-1:0] rdata;
  logic                 bram_ren, bram_wen;
  logic [ADDR_BITS-1:0] bram_addr;
  logic [DATA_BITS-1:0] bram_wdata;
  logic [DATA_BITS-1:0] bram_rdata;
  logic [7:0]           starve_events;

  modport slave (
    input  p0_req, p1_req, p2_req, p0_wen, p1_wen, p2_wen,
    input  p0_addr, p1_addr, p2_addr, p0_wdata, p1_wdata, p2_wdata,
    input  bram_rdata,
    output p0_gnt, p1_gnt, p2_gnt, p0_rvalid, p1_rvalid, p2_rvalid, rdata,
    output bram_ren, bram_wen, bram_addr, bram_wdata, starve_events
  );

  modport master (
    output p0_req, p1_req, p2_req, p0_wen, p1_wen, p2_wen,
    output p0_addr, p1_addr, p2_addr, p0_wdata, p1_wdata, p2_wdata,
    output bram_rdata,
    input  p0_gnt, p1_gnt, p2_gnt, p0_rvalid, p1_rvalid, p2_rvalid, rdata,
    input  bram_ren, bram_wen, bram_addr, bram_wdata, starve_events
  );
endinterface

// File: rtl/bram_arbiter.sv
// Three-port single-port-BRAM arbiter: port 0 fixed priority, ports 1/2 round-robin with
// starvation override; grant and BRAM drive are combinational, read data returns one cycle later.
module bram_arbiter #(
  parameter int ADDR_BITS    = 13,
  parameter int DATA_BITS    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst_sync,
  bram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    SEL_P0   = 2'd0,
    SEL_P1   = 2'd1,
    SEL_P2   = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [2:0] req;
  logic [2:0] wen;
  assign req = {bus.p2_req, bus.p1_req, bus.p0_req};
  assign wen = {bus.p2_wen, bus.p1_wen, bus.p0_wen};

  // rr_next: 0 selects port 1, 1 selects port 2
  logic                 rr_next_q, rr_next_d;
  logic [7:0]           wait1_q, wait1_d, wait2_q, wait2_d;
  logic [7:0]           starve_q, starve_d;
  logic                 tag_vld_q, tag_vld_d;
  logic [1:0]           tag_port_q, tag_port_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;

  logic starve1, starve2, forced, sel_wen, rv;
  sel_e sel;

  // Wait counters stop at the limit, so a port left waiting in a double-starve tie stays forced.
  always_comb begin
    starve1 = req[1] && (wait1_q == LIMIT);
    starve2 = req[2] && (wait2_q == LIMIT);
    sel     = SEL_NONE;
    if (rst_sync)                sel = SEL_NONE;
    else if (starve1 && starve2) sel = rr_next_q ? SEL_P2 : SEL_P1;
    else if (starve1)            sel = SEL_P1;
    else if (starve2)            sel = SEL_P2;
    else if (req[0])             sel = SEL_P0;
    else if (req[1] && req[2])   sel = rr_next_q ? SEL_P2 : SEL_P1;
    else if (req[1])             sel = SEL_P1;
    else if (req[2])             sel = SEL_P2;
    forced = !rst_sync && (starve1 || starve2) && req[0];
  end

  always_comb begin
    bus.p0_gnt     = 1'b0;
    bus.p1_gnt     = 1'b0;
    bus.p2_gnt     = 1'b0;
    sel_wen        = 1'b0;
    bus.bram_addr  = '0;
    bus.bram_wdata = '0;
    case (sel)
      SEL_P0: begin
        bus.p0_gnt     = 1'b1;
        sel_wen        = wen[0];
        bus.bram_addr  = bus.p0_addr;
        bus.bram_wdata = bus.p0_wdata;
      end
      SEL_P1: begin
        bus.p1_gnt     = 1'b1;
        sel_wen        = wen[1];
        bus.bram_addr  = bus.p1_addr;
        bus.bram_wdata = bus.p1_wdata;
      end
      SEL_P2: begin
        bus.p2_gnt     = 1'b1;
        sel_wen        = wen[2];
        bus.bram_addr  = bus.p2_addr;
        bus.bram_wdata = bus.p2_wdata;
      end
      default: ;
    endcase
    bus.bram_ren = (sel != SEL_NONE) && !sel_wen;
    bus.bram_wen = (sel != SEL_NONE) && sel_wen;
  end

  always_comb begin
    wait1_d = '0;
    wait2_d = '0;
    if (req[1] && !bus.p1_gnt) wait1_d = (wait1_q == LIMIT) ? wait1_q : wait1_q + 8'd1;
    if (req[2] && !bus.p2_gnt) wait2_d = (wait2_q == LIMIT) ? wait2_q : wait2_q + 8'd1;

    rr_next_d = rr_next_q;
    if (bus.p1_gnt)      rr_next_d = 1'b1;
    else if (bus.p2_gnt) rr_next_d = 1'b0;

    starve_d = starve_q;
    if (forced && (starve_q != 8'hFF)) starve_d = starve_q + 8'd1;

    tag_vld_d  = bus.bram_ren;
    tag_port_d = sel;
  end

  // Reset masks a tag captured just before it, so that read never reports.
  always_comb begin
    rv            = tag_vld_q && !rst_sync;
    bus.p0_rvalid = rv && (tag_port_q == 2'd0);
    bus.p1_rvalid = rv && (tag_port_q == 2'd1);
    bus.p2_rvalid = rv && (tag_port_q == 2'd2);
    rdata_d       = rdata_q;
    if (rst_sync) rdata_d = '0;
    else if (rv)  rdata_d = bus.bram_rdata;
    bus.rdata         = rdata_d;
    bus.starve_events = starve_q;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      rr_next_q  <= 1'b0;
      wait1_q    <= '0;
      wait2_q    <= '0;
      starve_q   <= '0;
      tag_vld_q  <= 1'b0;
      tag_port_q <= '0;
      rdata_q    <= '0;
    end else begin
      rr_next_q  <= rr_next_d;
      wait1_q    <= wait1_d;
      wait2_q    <= wait2_d;
      starve_q   <= starve_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: per-cycle vector table plus hand-written reset and RAW sequences.
module tb_bram_arbiter;

  localparam int AB = 13;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_sync;
  always #5 clk = ~clk;

  bram_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  bram_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (bus.slave)
  );

  // Behavioural single-port BRAM, 1-cycle read latency
  logic [DB-1:0] mem [8192];
  always @(posedge clk) begin
    if (bus.bram_wen) mem[bus.bram_addr] <= bus.bram_wdata;
    if (bus.bram_ren) bus.bram_rdata <= mem[bus.bram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] wen;
    logic [2:0] gnt;
    logic       ren;
    logic       bwen;
    logic [12:0] addr;
    logic [2:0] rv;
    logic [7:0] rdata;
    logic [7:0] sev;
  } vec_t;

  vec_t vt[$];

  localparam logic [12:0] A0 = 13'h0100;
  localparam logic [12:0] A1 = 13'h0010;
  localparam logic [12:0] A2 = 13'h0020;

  task automatic drive(input logic rst, input logic [2:0] req, input logic [2:0] wen);
    rst_sync   = rst;
    bus.p0_req = req[0];
    bus.p1_req = req[1];
    bus.p2_req = req[2];
    bus.p0_wen = wen[0];
    bus.p1_wen = wen[1];
    bus.p2_wen = wen[2];
  endtask

  function automatic logic [2:0] gnt_vec();
    return {bus.p2_gnt, bus.p1_gnt, bus.p0_gnt};
  endfunction

  function automatic logic [2:0] rv_vec();
    return {bus.p2_rvalid, bus.p1_rvalid, bus.p0_rvalid};
  endfunction

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[A0] = 8'hC3;
    mem[A1] = 8'hA5;
    mem[A2] = 8'h5A;
    bus.bram_rdata = '0;
    bus.p0_addr = A0;  bus.p1_addr = A1;  bus.p2_addr = A2;
    // write data equals preload so table writes leave memory unchanged
    bus.p0_wdata = 8'hC3; bus.p1_wdata = 8'hA5; bus.p2_wdata = 8'h5A;
    drive(1'b1, 3'b000, 3'b000);

    //          rst  req     wen     gnt     ren bwen addr   rv      rdata  sev
    vt.push_back('{1'b1, 3'b111, 3'b000, 3'b000, 0, 0, 13'h0, 3'b000, 8'h00, 8'd0});
    vt.push_back('{1'b0, 3'b010, 3'b000, 3'b010, 1, 0, A1,    3'b000, 8'h00, 8'd0});
    vt.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 0, 0, 13'h0, 3'b010, 8'hA5, 8'd0});
    vt.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 0, 0, 13'h0, 3'b000, 8'hA5, 8'd0});
    vt.push_back('{1'b0, 3'b110, 3'b000, 3'b100, 1, 0, A2,    3'b000, 8'hA5, 8'd0});
    vt.push_back('{1'b0, 3'b110, 3'b000, 3'b010, 1, 0, A1,    3'b100, 8'h5A, 8'd0});
    vt.push_back('{1'b0, 3'b110, 3'b000, 3'b100, 1, 0, A2,    3'b010, 8'hA5, 8'd0});
    vt.push_back('{1'b0, 3'b110, 3'b000, 3'b010, 1, 0, A1,    3'b100, 8'h5A, 8'd0});
    vt.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 0, 0, 13'h0, 3'b010, 8'hA5, 8'd0});
    vt.push_back('{1'b0, 3'b111, 3'b000, 3'b001, 1, 0, A0,    3'b000, 8'hA5, 8'd0});
    vt.push_back('{1'b0, 3'b111, 3'b000, 3'b001, 1, 0, A0,    3'b001, 8'hC3, 8'd0});
    vt.push_back('{1'b0, 3'b111, 3'b000, 3'b001, 1, 0, A0,    3'b001, 8'hC3, 8'd0});
    vt.push_back('{1'b0, 3'b111, 3'b000, 3'b001, 1, 0, A0,    3'b001, 8'hC3, 8'd0});
    vt.push_back('{1'b0, 3'b111, 3'b000, 3'b100, 1, 0, A2,    3'b001, 8'hC3, 8'd0});
    vt.push_back('{1'b0, 3'b111, 3'b000, 3'b010, 1, 0, A1,    3'b100, 8'h5A, 8'd1});
    vt.push_back('{1'b0, 3'b111, 3'b000, 3'b001, 1, 0, A0,    3'b010, 8'hA5, 8'd2});
    vt.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 0, 0, 13'h0, 3'b001, 8'hC3, 8'd2});
    vt.push_back('{1'b0, 3'b100, 3'b100, 3'b100, 0, 1, A2,    3'b000, 8'hC3, 8'd2});
    vt.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 0, 0, 13'h0, 3'b000, 8'hC3, 8'd2});
    vt.push_back('{1'b0, 3'b011, 3'b000, 3'b001, 1, 0, A0,    3'b000, 8'hC3, 8'd2});
    vt.push_back('{1'b0, 3'b011, 3'b000, 3'b001, 1, 0, A0,    3'b001, 8'hC3, 8'd2});
    vt.push_back('{1'b0, 3'b011, 3'b000, 3'b001, 1, 0, A0,    3'b001, 8'hC3, 8'd2});
    vt.push_back('{1'b0, 3'b011, 3'b000, 3'b001, 1, 0, A0,    3'b001, 8'hC3, 8'd2});
    vt.push_back('{1'b0, 3'b011, 3'b000, 3'b010, 1, 0, A1,    3'b001, 8'hC3, 8'd2});
    vt.push_back('{1'b0, 3'b011, 3'b000, 3'b001, 1, 0, A0,    3'b010, 8'hA5, 8'd3});
    vt.push_back('{1'b0, 3'b000, 3'b000, 3'b000, 0, 0, 13'h0, 3'b001, 8'hC3, 8'd3});

    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].req, vt[i].wen);
      #1;
      chk($sformatf("v%0d gnt", i),   32'(gnt_vec()),         32'(vt[i].gnt));
      chk($sformatf("v%0d ren", i),   32'(bus.bram_ren),      32'(vt[i].ren));
      chk($sformatf("v%0d wen", i),   32'(bus.bram_wen),      32'(vt[i].bwen));
      chk($sformatf("v%0d addr", i),  32'(bus.bram_addr),     32'(vt[i].addr));
      chk($sformatf("v%0d rvalid", i), 32'(rv_vec()),         32'(vt[i].rv));
      chk($sformatf("v%0d rdata", i), 32'(bus.rdata),         32'(vt[i].rdata));
      chk($sformatf("v%0d starve", i), 32'(bus.starve_events), 32'(vt[i].sev));
    end

    // Reset mid-read: p2 read issued, reset next cycle swallows its rvalid
    @(negedge clk); drive(1'b0, 3'b100, 3'b000); #1;
    chk("rst_mid gnt T", 32'(gnt_vec()), 32'(3'b100));
    @(negedge clk); drive(1'b1, 3'b000, 3'b000); #1;
    chk("rst_mid rvalid T+1", 32'(rv_vec()), 32'(3'b000));
    chk("rst_mid rdata T+1", 32'(bus.rdata), 32'h0);
    chk("rst_mid gnt T+1", 32'(gnt_vec()), 32'(3'b000));
    @(negedge clk); drive(1'b0, 3'b110, 3'b000); #1;
    chk("rst_mid starve T+2", 32'(bus.starve_events), 32'h0);
    chk("rst_mid rvalid T+2", 32'(rv_vec()), 32'(3'b000));
    chk("post_rst rr gnt", 32'(gnt_vec()), 32'(3'b010));
    @(negedge clk); drive(1'b0, 3'b000, 3'b000); #1;
    chk("post_rst rvalid", 32'(rv_vec()), 32'(3'b010));
    chk("post_rst rdata", 32'(bus.rdata), 32'hA5);

    // Write then read of the same address on consecutive cycles
    bus.p1_addr = 13'h1FFF; bus.p1_wdata = 8'h3C; bus.p0_addr = 13'h1FFF;
    @(negedge clk); drive(1'b0, 3'b010, 3'b010); #1;
    chk("raw gnt T", 32'(gnt_vec()), 32'(3'b010));
    chk("raw bram_wen T", 32'(bus.bram_wen), 32'h1);
    chk("raw bram_addr T", 32'(bus.bram_addr), 32'h1FFF);
    chk("raw bram_wdata T", 32'(bus.bram_wdata), 32'h3C);
    @(negedge clk); drive(1'b0, 3'b001, 3'b000); #1;
    chk("raw gnt T+1", 32'(gnt_vec()), 32'(3'b001));
    chk("raw bram_ren T+1", 32'(bus.bram_ren), 32'h1);
    chk("raw no write rvalid", 32'(rv_vec()), 32'(3'b000));
    @(negedge clk); drive(1'b0, 3'b000, 3'b000); #1;
    chk("raw rvalid T+2", 32'(rv_vec()), 32'(3'b001));
    chk("raw rdata T+2", 32'(bus.rdata), 32'h3C);
    @(negedge clk); #1;
    chk("raw rvalid single", 32'(rv_vec()), 32'(3'b000));
    chk("raw rdata held", 32'(bus.rdata), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 13, the BRAM address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, the BRAM data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 16, the max consecutive denied cycles for port 1 or 2 before forced grant (legal 1..255).
REQ-004 SHALL use a single clock and a synchronous, active-high reset: clk input 1, the 100 MHz system clock; rst_sync input 1, synchronous active-high reset.
REQ-005 SHALL have pN_req input 1 (N=0,1,2), the access request; port 0 is the pattern generator, port 1 is the SPI-slave BRAM bridge, port 2 is the capture logger.
REQ-006 SHALL have pN_wen input 1, write (1) or read (0), sampled with pN_req.
REQ-007 SHALL have pN_addr input ADDR_BITS and pN_wdata input DATA_BITS.
REQ-008 SHALL have pN_gnt output 1, asserted in the cycle the port's access is issued.
REQ-009 SHALL have pN_rvalid output 1, read data valid for port N.
REQ-010 SHALL have rdata output DATA_BITS, read data shared by all ports and qualified by pN_rvalid.
REQ-011 SHALL have bram_ren output 1, bram_wen output 1, bram_addr output ADDR_BITS, bram_wdata output DATA_BITS, and bram_rdata input DATA_BITS, connecting to the single-port BRAM (1-cycle read latency).
REQ-012 SHALL have starve_events output 8, a saturating count of forced grants.

Function
REQ-013 SHALL grant at most one port per cycle; exactly one pN_gnt is high when any pN_req is high, otherwise none.
REQ-014 SHALL drive bram_* combinationally from the granted port in the grant cycle: bram_ren = gnt & ~wen, bram_wen = gnt & wen; with no grant, ren = wen = 0 and addr/wdata = 0.
REQ-015 SHALL give port 0 fixed priority over ports 1 and 2, except under REQ-018.
REQ-016 SHALL arbitrate ports 1 and 2 round-robin: 1-bit pointer rr_next; on a grant to port 1 or 2, rr_next flips to the other port.
REQ-017 SHALL keep per-port wait counters wait1 and wait2 (8 bit): increment when req=1 and gnt=0; clear on grant or req=0.
REQ-018 SHALL, when wait1 or wait2 equals STARVE_LIMIT, grant that port in the current cycle even if p0_req=1; if both are starved, grant the one selected by rr_next.
REQ-019 SHALL increment starve_events by 1 per forced grant that displaced an active p0_req, saturating at 255.
REQ-020 SHALL register a read-issue tag (valid plus 2-bit port id) in the grant cycle and, one cycle later, assert pN_rvalid for that port for exactly 1 cycle with rdata = bram_rdata.
REQ-021 SHALL never assert pN_rvalid for write grants.
REQ-022 SHALL keep rdata at its last value when no rvalid is asserted.
REQ-023 SHALL treat back-to-back reads from any mix of ports as fully pipelined: one grant per cycle and one rvalid per cycle, in grant order.
REQ-024 SHALL leave requests held by the requester until gnt; the arbiter does not queue, and a request deasserted before gnt is dropped without effect.
REQ-025 SHALL, when a write and a read to the same address are granted in consecutive cycles, return the newly written data (the BRAM is read-after-write ordered by issue).

Reset
REQ-026 SHALL, while rst_sync=1, hold all pN_gnt, pN_rvalid, bram_ren, and bram_wen at 0, and bram_addr, bram_wdata, and rdata at 0.
REQ-027 SHALL reset rr_next to port 1 and wait1, wait2, and starve_events to 0.
REQ-028 SHALL discard the read tag on reset; a read granted in the cycle before rst_sync rises produces no rvalid.
REQ-029 SHALL accept requests in the first cycle after rst_sync falls.

Verification
REQ-030 Single read: p1_req=1, wen=0, addr=0x0010, BRAM[0x10]=0xA5 -> p1_gnt in cycle T, bram_ren=1 with addr 0x0010 in T, p1_rvalid=1 with rdata=0xA5 in T+1.
REQ-031 Priority: p0, p1, p2 req all high for 3 cycles; rr_next=1 -> grants p0, p0, p0 while wait1 and wait2 count 1, 2, 3.
REQ-032 Starvation: STARVE_LIMIT=4, p0 and p1 held high -> p0 granted for 4 cycles, p1 forced in cycle 5, then p0 again, and starve_events=1.
REQ-033 Round-robin: p1 and p2 held high, p0 idle -> grants alternate p1, p2, p1, p2; each read rvalid arrives 1 cycle after its own grant to the correct port.
REQ-034 Reset mid-read: p2 read granted in cycle T, rst_sync=1 in T+1 -> p2_rvalid stays 0, and all counters are 0 in T+2.
REQ-035 Write then read: p1 writes 0x3C to 0x1FFF in T, and p0 reads 0x1FFF in T+1 -> p0_rvalid in T+2 with rdata=0x3C, and no rvalid for the write.
